fp8_mul_rr_scheduler: RTL and testbench
=======================================

// Module: fp8_mul_rr_scheduler
// PURPOSE
//   Shares one FP8(E5M2)xFP8->FP32 multiplier datapath (fp_8_to_32_multiplier) among NUM_REQ requesters.
//   Round-robin arbitration, valid/ready on every requester and on the result port.
//   Two-stage pipeline (operand reg -> result reg) with full backpressure. Results carry the requester ID.
//   Sits between per-lane FP8 producers and the FP32 accumulate/writeback path.
// PARAMETERS
//   NUM_REQ   4                    number of requesters, >=2
//   ID_W      $clog2(NUM_REQ)      width of requester ID tag (localparam)
// PORTS
//   clk        in   1             clock; all state updates on posedge
//   rstn       in   1             reset, synchronous, active-high (asserted = 1)
//   req_valid  in   NUM_REQ       requester i has operands ready
//   req_ready  out  NUM_REQ       one-hot grant; handshake when req_valid[i]&req_ready[i]
//   req_a      in   8*NUM_REQ     operand A of requester i at [8*i+:8]
//   req_b      in   8*NUM_REQ     operand B of requester i at [8*i+:8]
//   out_valid  out  1             result register holds a valid product
//   out_ready  in   1             consumer accepts result
//   out_data   out  32            FP32 product
//   out_id     out  ID_W          index of requester that issued out_data
// BEHAVIOUR
//   Reset (rstn=1 at posedge): s1_valid=0, out_valid=0, rr_ptr=0, out_data=0, out_id=0, stat counters=0.
//     All in-flight operations are dropped, including when reset is asserted mid-operation. req_ready is 0 while rstn=1.
//   Stages:
//     S1 = {a,b,id,s1_valid}. S2 = {out_data,out_id,out_valid}; S2 is the output register.
//     s2_free = !out_valid | out_ready
//     s1_free = !s1_valid | s2_free
//   Grant (combinational):
//     If s1_free, grant the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     req_ready is one-hot or zero; it never depends on out_valid except through s1_free.
//   Pointer: on handshake with requester g, rr_ptr <= (g+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0). Otherwise held.
//   S1 load: on handshake, S1 <= {req_a[g], req_b[g], g, 1}. Else if s2_free, s1_valid <= 0.
//   S2 load: if s2_free, {out_data,out_id,out_valid} <= {mul(S1.a,S1.b), S1.id, s1_valid}.
//     out_data/out_id update only when loading a valid S1 entry, else held.
//   Latency: handshake at edge N -> out_valid=1 after edge N+1. Throughput 1/cycle with out_ready=1.
//   Backpressure: while out_valid & !out_ready, out_data/out_id are stable.
//     Pipeline holds at most 2 entries; once both are full, req_ready=0.
//   Simultaneous events: out_ready pop and new grant in the same cycle are both honoured, with no bubble.
//   Product arithmetic is entirely the multiplier's, including NaN, Inf, zero and subnormal handling; this block does no rounding or reformatting.
// CONFIGURATION
//   FP8_MUL_ARB_STATS_EN defined:
//     Adds port stat_grants out 16*NUM_REQ: per-requester grant counters at [16*i+:16].
//     Each counter increments on every handshake with requester i and saturates at 16'hFFFF.
//     Counters clear on reset only.
//   Not defined: port absent, no counter logic.
// TESTING
//   T1 single op: req 0 a=0x3C b=0x3C (1.0*1.0), out_ready=1 -> out_valid next cycle after grant, out_data=0x3F800000, out_id=0.
//   T2 sign/scale: req 2 a=0x40 b=0xBC -> out_data=0xC0000000, out_id=2. Then a=0x7D b=0x3C -> 0x7FFFFFFF (NaN).
//   T3 fairness: all req_valid=1 continuously, out_ready=1 -> grants 0,1,2,3,0,1..., one per cycle; out_id follows the same sequence.
//   T4 backpressure: all valid, out_ready=0 -> 2 handshakes, then req_ready=0 and out_data stable.
//     Release out_ready=1 -> the 2 held results drain in order, grants resume at the next rr_ptr.
//   T5 wrap/skip: only req 3 and req 1 valid, rr_ptr=2 -> grant 3, then 1; rr_ptr goes 0, then 2.
//   T6 reset mid-flight: rstn=1 with both stages full -> next cycle out_valid=0, req_ready=0, rr_ptr=0.
//     With STATS_EN, all stat_grants=0.

Source files
------------

// File: rtl/fp8_mul_rr_scheduler.sv
// Round-robin scheduler sharing one FP8(E5M2) x FP8 -> FP32 multiplier across NUM_REQ lanes.
// Optional per-lane grant counters are compiled in when FP8_MUL_ARB_STATS_EN is defined.

module fp_8_to_32_multiplier (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [31:0] p_o
);
    logic [4:0] ea, eb;
    logic [1:0] ma, mb;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic [2:0] sig_a, sig_b;
    logic [4:0] exp_a, exp_b;
    logic [5:0] prod, norm;
    logic [2:0] lead;
    logic [8:0] exp32;

    assign ea     = a_i[6:2];
    assign eb     = b_i[6:2];
    assign ma     = a_i[1:0];
    assign mb     = b_i[1:0];
    assign sgn    = a_i[7] ^ b_i[7];
    assign a_nan  = (ea == 5'h1F) && (ma != 2'd0);
    assign b_nan  = (eb == 5'h1F) && (mb != 2'd0);
    assign a_inf  = (ea == 5'h1F) && (ma == 2'd0);
    assign b_inf  = (eb == 5'h1F) && (mb == 2'd0);
    assign a_zero = (ea == 5'h00) && (ma == 2'd0);
    assign b_zero = (eb == 5'h00) && (mb == 2'd0);

    // Subnormals share the minimum exponent with an implicit leading 0.
    assign sig_a = {(ea != 5'h00), ma};
    assign sig_b = {(eb != 5'h00), mb};
    assign exp_a = (ea == 5'h00) ? 5'd1 : ea;
    assign exp_b = (eb == 5'h00) ? 5'd1 : eb;
    assign prod  = {3'b000, sig_a} * {3'b000, sig_b};

    always_comb begin
        lead = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (prod[i]) lead = 3'(i);
        end
    end

    // The 6-bit product always fits the FP32 fraction, so the result is exact.
    assign norm  = prod << (3'd5 - lead);
    assign exp32 = {4'b0000, exp_a} + {4'b0000, exp_b} + 9'd93 + {6'b000000, lead};

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p_o = 32'h7FFF_FFFF;
        end else if (a_inf || b_inf) begin
            p_o = {sgn, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            p_o = {sgn, 31'h0};
        end else begin
            p_o = {sgn, exp32[7:0], norm[4:0], 18'h0};
        end
    end
endmodule

module fp8_mul_rr_scheduler #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [ID_W-1:0]      out_id
`ifdef FP8_MUL_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0] stat_grants
`endif
);
    logic [7:0]      s1_a_q, s1_b_q;
    logic [ID_W-1:0] s1_id_q;
    logic            s1_valid_q;
    logic [31:0]     out_data_q;
    logic [ID_W-1:0] out_id_q;
    logic            out_valid_q;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            s2_free, s1_free;
    logic            found;
    logic [ID_W-1:0] gidx;
    logic [ID_W:0]   scan_idx;
    logic [7:0]      sel_a, sel_b;
    logic [31:0]     mul_p;

    assign s2_free = !out_valid_q || out_ready;
    assign s1_free = !s1_valid_q || s2_free;

    // Scan from the pointer; reset blocks every grant.
    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        scan_idx = '0;
        if (s1_free && !rstn) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (scan_idx >= (ID_W+1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
                if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
                    found = 1'b1;
                    gidx  = scan_idx[ID_W-1:0];
                end
            end
        end
    end

    assign req_ready = found ? (NUM_REQ'(1) << gidx) : '0;
    assign rr_ptr_d  = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
    assign sel_a     = req_a[{gidx, 3'b000} +: 8];
    assign sel_b     = req_b[{gidx, 3'b000} +: 8];

    fp_8_to_32_multiplier u_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            s1_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            if (found) begin
                s1_a_q     <= sel_a;
                s1_b_q     <= sel_b;
                s1_id_q    <= gidx;
                s1_valid_q <= 1'b1;
                rr_ptr_q   <= rr_ptr_d;
            end else if (s2_free) begin
                s1_valid_q <= 1'b0;
            end
            // Data/id only move with a valid entry so the last result stays visible.
            if (s2_free) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= mul_p;
                    out_id_q   <= s1_id_q;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef FP8_MUL_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (found && (stat_q[gidx] != 16'hFFFF)) begin
            stat_q[gidx] <= stat_q[gidx] + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        assign stat_grants[16*i +: 16] = stat_q[i];
    end
`endif
endmodule

// File: tb/tb_fp8_mul_rr_scheduler.sv
// Scoreboard bench for fp8_mul_rr_scheduler: stimulus predicts grants and products,
// an independent monitor pops and compares every accepted result.

module tb_fp8_mul_rr_scheduler;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [31:0]    out_data;
    logic [IW-1:0]  out_id;
`ifdef FP8_MUL_ARB_STATS_EN
    logic [16*N-1:0] stat_grants;
`endif

    fp8_mul_rr_scheduler #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef FP8_MUL_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   data;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr   = 0;
    int   m_occ   = 0;
    bit   m_ov    = 0;
    int   m_cnt[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real fp8_real(input logic [7:0] x);
        real mag;
        int  e;
        e = int'(x[6:2]);
        if (e == 0) mag = (real'(int'(x[1:0])) / 4.0) * (2.0 ** (-14));
        else        mag = (1.0 + real'(int'(x[1:0])) / 4.0) * (2.0 ** (e - 15));
        return x[7] ? -mag : mag;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        bit          xn, yn, xi, yi, xz, yz, s;
        real         p;
        logic [63:0] bits;
        int          e;
        xn = (x[6:2] == 5'h1F) && (x[1:0] != 0);
        yn = (y[6:2] == 5'h1F) && (y[1:0] != 0);
        xi = (x[6:2] == 5'h1F) && (x[1:0] == 0);
        yi = (y[6:2] == 5'h1F) && (y[1:0] == 0);
        xz = (x[6:0] == 7'h00);
        yz = (y[6:0] == 7'h00);
        s  = x[7] ^ y[7];
        if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FFF_FFFF;
        if (xi || yi) return {s, 8'hFF, 23'h0};
        if (xz || yz) return {s, 31'h0};
        p    = fp8_real(x) * fp8_real(y);
        bits = $realtobits(p);
        e    = int'(bits[62:52]) - 1023 + 127;
        return {bits[63], 8'(e), bits[51:29]};
    endfunction

    function automatic logic [8*N-1:0] lane(input int l, input logic [7:0] x);
        logic [8*N-1:0] v;
        v = '0;
        v[8*l +: 8] = x;
        return v;
    endfunction

    function automatic logic [8*N-1:0] rnd_ops();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    // One clock of stimulus plus the model's prediction for that clock.
    task automatic cycle(input logic [N-1:0] v, input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                         input bit ordy, input bit rst);
        logic [N-1:0] eg;
        int g;
        bit pop;
        @(posedge clk);
        #1;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        out_ready = ordy;
        rstn      = rst;
        #1;
        if (rst) begin
            check("ready_in_reset", 64'(req_ready), 64'(0));
            m_ptr = 0;
            m_occ = 0;
            m_ov  = 0;
            sbq.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            eg = '0;
            g  = -1;
            if (m_occ < 2 || (m_ov && ordy)) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            if (g >= 0) eg[g] = 1'b1;
            check("grant", 64'(req_ready), 64'(eg));
            check("out_valid", 64'(out_valid), 64'(m_ov));
`ifdef FP8_MUL_ARB_STATS_EN
            for (int i = 0; i < N; i++) check("stat_grants", 64'(stat_grants[16*i +: 16]), 64'(m_cnt[i]));
`endif
            pop = m_ov && ordy;
            if (g >= 0) begin
                sbq.push_back('{id: IW'(g), data: ref_mul(a[8*g +: 8], b[8*g +: 8])});
                m_ptr = (g + 1) % N;
                if (m_cnt[g] < 65535) m_cnt[g]++;
            end
            m_ov  = (m_occ - int'(pop)) >= 1;
            m_occ = m_occ + int'(g >= 0) - int'(pop);
        end
    endtask

    logic [31:0]   last_data;
    logic [IW-1:0] last_id;
    bit            held = 0;

    always @(negedge clk) begin
        if (rstn) begin
            held = 0;
        end else begin
            if (held) begin
                check("hold_data", 64'(out_data), 64'(last_data));
                check("hold_id", 64'(out_id), 64'(last_id));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 64'(1), 64'(0));
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_data", 64'(out_data), 64'(mon_e.data));
                    check("out_id", 64'(out_id), 64'(mon_e.id));
                end
                held = 0;
            end else begin
                held      = out_valid;
                last_data = out_data;
                last_id   = out_id;
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        cycle('0, '0, '0, 1'b1, 1'b1);
        cycle('0, '0, '0, 1'b1, 1'b1);
        cycle('0, '0, '0, 1'b1, 1'b0);
        check("reset_out_data", 64'(out_data), 64'(0));
        check("reset_out_id", 64'(out_id), 64'(0));

        // Single op, then sign/scale and NaN on lane 2.
        cycle(4'b0001, lane(0, 8'h3C), lane(0, 8'h3C), 1'b1, 1'b0);
        cycle('0, '0, '0, 1'b1, 1'b0);
        cycle('0, '0, '0, 1'b1, 1'b0);
        cycle(4'b0100, lane(2, 8'h40), lane(2, 8'hBC), 1'b1, 1'b0);
        cycle(4'b0100, lane(2, 8'h7D), lane(2, 8'h3C), 1'b1, 1'b0);
        cycle('0, '0, '0, 1'b1, 1'b0);
        cycle('0, '0, '0, 1'b1, 1'b0);

        // Fairness with everyone requesting.
        for (int i = 0; i < 12; i++) cycle('1, rnd_ops(), rnd_ops(), 1'b1, 1'b0);

        // Backpressure, then release.
        for (int i = 0; i < 6; i++) cycle('1, rnd_ops(), rnd_ops(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle('1, rnd_ops(), rnd_ops(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle('0, '0, '0, 1'b1, 1'b0);

        // Wrap/skip: park the pointer at 2, then only lanes 3 and 1 request.
        cycle(4'b0010, rnd_ops(), rnd_ops(), 1'b1, 1'b0);
        cycle(4'b1010, rnd_ops(), rnd_ops(), 1'b1, 1'b0);
        cycle(4'b1010, rnd_ops(), rnd_ops(), 1'b1, 1'b0);
        cycle(4'b1010, rnd_ops(), rnd_ops(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle('0, '0, '0, 1'b1, 1'b0);

        // Reset with both stages full.
        for (int i = 0; i < 3; i++) cycle('1, rnd_ops(), rnd_ops(), 1'b0, 1'b0);
        cycle('1, rnd_ops(), rnd_ops(), 1'b0, 1'b1);
        cycle('0, '0, '0, 1'b0, 1'b0);
        check("post_reset_data", 64'(out_data), 64'(0));
        cycle('1, rnd_ops(), rnd_ops(), 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(N'($urandom), rnd_ops(), rnd_ops(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 6; i++) cycle('0, '0, '0, 1'b1, 1'b0);
        check("drain_empty", 64'(sbq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
